// File: rtl/river_seq_if.sv
// river_seq_if: frog/level inputs and per-row configuration and drift outputs of the river sequencer.
interface river_seq_if;
    logic            Level_Start;
    logic [2:0]      Level;
    logic [10:0]     Frog_Y;
    logic            Frog_Hop;
    logic [3:0]      Row_Collision;
    logic [3:0][2:0] Row_Number_LPads;
    logic [3:0][7:0] Row_Gap_Size;
    logic [3:0][5:0] Row_Speed;
    logic [3:0]      Row_Direction;
    logic [3:0]      Row_Enable;
    logic            Drift_Valid;
    logic            Drift_Dir;
    logic [5:0]      Drift_Speed;
    logic            Drown;
    logic            Busy;
    modport master (
        output Level_Start, Level, Frog_Y, Frog_Hop, Row_Collision,
        input  Row_Number_LPads, Row_Gap_Size, Row_Speed, Row_Direction, Row_Enable,
        input  Drift_Valid, Drift_Dir, Drift_Speed, Drown, Busy
    );
    modport slave (
        input  Level_Start, Level, Frog_Y, Frog_Hop, Row_Collision,
        output Row_Number_LPads, Row_Gap_Size, Row_Speed, Row_Direction, Row_Enable,
        output Drift_Valid, Drift_Dir, Drift_Speed, Drown, Busy
    );
endinterface

// File: rtl/river_sequencer.sv
// river_sequencer: per-level river row configuration, row release and frog drown detection.
// Define RIVER_SEQ_STAGGER_EN to release rows one at a time; otherwise all rows start together.
module river_sequencer #(
    parameter logic [10:0] RIVER_TOP      = 11'd80,
    parameter logic [10:0] ROW_HEIGHT     = 11'd40,
    parameter int          GRACE_FRAMES   = 4,
    parameter int          STAGGER_FRAMES = 8
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    river_seq_if.slave rs
);
    localparam int MW = $clog2(GRACE_FRAMES + 1);
    localparam int CW = $clog2(3 * STAGGER_FRAMES + 1);
    typedef enum logic [2:0] {IDLE, LOAD, STAGGER, RUN, DROWN} state_t;
    state_t          state_q, state_d;
    logic            ret_stg_q, ret_stg_d;
    logic [2:0]      lvl_q, lvl_d;
    logic [3:0]      row_en_q, row_en_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic [3:0][2:0] npads_q, npads_d;
    logic [3:0][7:0] gap_q, gap_d;
    logic [3:0][5:0] speed_q, speed_d;
    logic [3:0]      dir_q, dir_d;
    logic [3:0]      in_row, ride;
    logic [7:0]      gap_raw;
    logic            active;
    // Row bands found by comparing against constant boundaries, no division
    for (genvar k = 0; k < 4; k++) begin : g_row
        assign in_row[k] = ({1'b0, rs.Frog_Y} >= 12'(RIVER_TOP + k * ROW_HEIGHT)) &&
                           ({1'b0, rs.Frog_Y} <  12'(RIVER_TOP + (k + 1) * ROW_HEIGHT));
    end
    assign ride    = in_row & row_en_q & rs.Row_Collision;
    assign active  = (state_q == STAGGER) || (state_q == RUN);
    assign gap_raw = 8'd120 - {2'b00, lvl_q, 3'b000};
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            ret_stg_q <= 1'b0;
            lvl_q     <= '0;
            row_en_q  <= '0;
            cnt_q     <= '0;
            miss_q    <= '0;
            npads_q   <= '0;
            gap_q     <= '0;
            speed_q   <= '0;
            dir_q     <= '0;
        end else begin
            state_q   <= state_d;
            ret_stg_q <= ret_stg_d;
            lvl_q     <= lvl_d;
            row_en_q  <= row_en_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            npads_q   <= npads_d;
            gap_q     <= gap_d;
            speed_q   <= speed_d;
            dir_q     <= dir_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        ret_stg_d = ret_stg_q;
        lvl_d     = lvl_q;
        row_en_d  = row_en_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        npads_d   = npads_q;
        gap_d     = gap_q;
        speed_d   = speed_q;
        dir_d     = dir_q;
        if (active)
            miss_d = (rs.Frog_Hop || !(|in_row) || (|ride)) ? '0 :
                     (miss_q == MW'(GRACE_FRAMES)) ? miss_q : miss_q + 1'b1;
        if (state_q == STAGGER) begin
            cnt_d = cnt_q + 1'b1;
            for (int k = 1; k < 4; k++)
                if (cnt_d == CW'(k * STAGGER_FRAMES)) row_en_d[k] = 1'b1;
            if (row_en_d[3]) state_d = RUN;
        end
        if (state_q == LOAD) begin
            for (int r = 0; r < 4; r++) begin
                npads_d[r] = 3'(2 + (int'(lvl_q) + r) % 3);
                gap_d[r]   = (gap_raw < 8'd64) ? 8'd64 : gap_raw;
                speed_d[r] = 6'(1 + int'(lvl_q) + r);
                dir_d[r]   = lvl_q[0] ^ r[0];
            end
`ifdef RIVER_SEQ_STAGGER_EN
            state_d  = STAGGER;
            row_en_d = 4'b0001;
`else
            state_d  = RUN;
            row_en_d = 4'b1111;
`endif
        end
        if (state_q == DROWN) begin
            miss_d  = '0;
            state_d = ret_stg_q ? STAGGER : RUN;
        end
        // Return target follows any same-cycle STAGGER->RUN promotion
        if (active && miss_d == MW'(GRACE_FRAMES)) begin
            ret_stg_d = (state_d == STAGGER);
            state_d   = DROWN;
        end
        if (rs.Level_Start) begin
            state_d  = LOAD;
            lvl_d    = rs.Level;
            row_en_d = '0;
            cnt_d    = '0;
            miss_d   = '0;
        end
    end
    always_comb begin
        rs.Drift_Speed = '0;
        for (int k = 0; k < 4; k++)
            if (active && ride[k]) rs.Drift_Speed = speed_q[k];
        rs.Drift_Valid = active && (|ride);
        rs.Drift_Dir   = active && (|(ride & dir_q));
        rs.Drown       = (state_q == DROWN);
        rs.Busy        = (state_q != IDLE);
    end
    assign rs.Row_Enable       = row_en_q;
    assign rs.Row_Number_LPads = npads_q;
    assign rs.Row_Gap_Size     = gap_q;
    assign rs.Row_Speed        = speed_q;
    assign rs.Row_Direction    = dir_q;
endmodule
